// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle control FSM for the 16-bit CPU datapath.
// Owns pc, ir and the retired-instruction counter, and walks each
// instruction through FETCH/DECODE/EXEC/MEM/WB. Register-file and
// data-memory write enables are gated by the current state.
module cpu_sequencer #(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter logic [15:0] HALT_INSTR = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic [15:0] instruction,
    input  logic        jump,
    input  logic        branch,
    input  logic        memwrite,
    input  logic        memtoreg,
    input  logic        regwrite,
    input  logic        is_zero,
    input  logic        mem_ready,
    output logic [15:0] pc,
    output logic [15:0] ir,
    output logic        regwrite_en,
    output logic        memwrite_en,
    output logic [2:0]  state,
    output logic        halted,
    output logic [15:0] retired
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    logic [15:0] retired_q, retired_d;
    logic [15:0] pc_inc;
    logic [15:0] br_off;

    // Retire counter sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign pc_inc = pc_q + 16'd1;
    assign br_off = {{9{ir_q[6]}}, ir_q[6:0]};

    // State, pc, ir and retired counter registers with async reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            ir_q      <= 16'h0000;
            retired_q <= 16'h0000;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            retired_q <= retired_d;
        end
    end

    // Next-state logic: each instruction either retires back to FETCH or halts.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        retired_d = retired_q;
        case (state_q)
            S_IDLE: begin
                pc_d = RESET_PC;
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (run) begin
                    ir_d    = instruction;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                state_d = (ir_q == HALT_INSTR) ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                if (jump) begin
                    pc_d      = {pc_q[15:13], ir_q[12:0]};
                    retired_d = sat_inc(retired_q);
                    state_d   = S_FETCH;
                end else if (branch) begin
                    pc_d      = is_zero ? (pc_inc + br_off) : pc_inc;
                    retired_d = sat_inc(retired_q);
                    state_d   = S_FETCH;
                end else if (memwrite || memtoreg) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (mem_ready) begin
                    if (memtoreg) begin
                        state_d = S_WB;
                    end else begin
                        pc_d      = pc_inc;
                        retired_d = sat_inc(retired_q);
                        state_d   = S_FETCH;
                    end
                end
            end
            S_WB: begin
                pc_d      = pc_inc;
                retired_d = sat_inc(retired_q);
                state_d   = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign pc          = pc_q;
    assign ir          = ir_q;
    assign retired     = retired_q;
    assign state       = state_q;
    assign halted      = (state_q == S_HALT);
    assign regwrite_en = (state_q == S_WB)  && regwrite;
    assign memwrite_en = (state_q == S_MEM) && memwrite;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: scoreboard bench for cpu_sequencer. The bench plays
// imem and control decode; a reference model pushes the expected outcome
// of each instruction, which is popped when the DUT returns to FETCH.
module tb_cpu_sequencer;

    logic        clk;
    logic        rst_n;
    logic        run;
    logic [15:0] instruction;
    logic        jump, branch, memwrite, memtoreg, regwrite;
    logic        is_zero;
    logic        mem_ready;
    logic [15:0] pc, ir, retired;
    logic        regwrite_en, memwrite_en, halted;
    logic [2:0]  state;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [15:0] pc;
        int          cyc;
        logic [15:0] ret;
        int          rw;
        int          mw;
        int          memc;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] mpc;
    logic [15:0] mret;

    cpu_sequencer #(.RESET_PC(16'h0000), .HALT_INSTR(16'hFFFF)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .instruction(instruction),
        .jump(jump), .branch(branch), .memwrite(memwrite),
        .memtoreg(memtoreg), .regwrite(regwrite), .is_zero(is_zero),
        .mem_ready(mem_ready), .pc(pc), .ir(ir), .regwrite_en(regwrite_en),
        .memwrite_en(memwrite_en), .state(state), .halted(halted),
        .retired(retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bench control decode: ir[15:13] selects the instruction class.
    always_comb begin
        jump = 1'b0; branch = 1'b0; memwrite = 1'b0; memtoreg = 1'b0; regwrite = 1'b0;
        case (ir[15:13])
            3'b000: regwrite = 1'b1;
            3'b001: branch = 1'b1;
            3'b010: jump = 1'b1;
            3'b011: begin jump = 1'b1; branch = 1'b1; end
            3'b100: memwrite = 1'b1;
            3'b101: begin memtoreg = 1'b1; regwrite = 1'b1; end
            3'b110: begin memwrite = 1'b1; memtoreg = 1'b1; regwrite = 1'b1; end
            default: ;
        endcase
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Reference model for one non-halt instruction.
    function automatic exp_t model(input logic [15:0] w, input logic z, input int stall);
        exp_t e;
        logic [2:0] op;
        op = w[15:13];
        e.rw = 0; e.mw = 0; e.memc = 0;
        case (op)
            3'b010, 3'b011: begin e.pc = {mpc[15:13], w[12:0]}; e.cyc = 3; end
            3'b001: begin
                e.pc  = z ? (mpc + 16'd1 + {{9{w[6]}}, w[6:0]}) : (mpc + 16'd1);
                e.cyc = 3;
            end
            3'b100: begin e.pc = mpc + 16'd1; e.cyc = 4 + stall; e.mw = stall + 1; e.memc = stall + 1; end
            3'b101: begin e.pc = mpc + 16'd1; e.cyc = 5 + stall; e.rw = 1; e.memc = stall + 1; end
            3'b110: begin e.pc = mpc + 16'd1; e.cyc = 5 + stall; e.rw = 1; e.mw = stall + 1; e.memc = stall + 1; end
            3'b000: begin e.pc = mpc + 16'd1; e.cyc = 4; e.rw = 1; end
            default: begin e.pc = mpc + 16'd1; e.cyc = 4; end
        endcase
        e.ret = (mret == 16'hFFFF) ? mret : mret + 16'd1;
        return e;
    endfunction

    // Run one instruction from FETCH back to FETCH; called at a negedge in FETCH.
    task automatic exec_instr(input logic [15:0] w, input logic z, input int stall);
        exp_t e, got;
        int   stl;
        e = model(w, z, stall);
        sb.push_back(e);
        mpc = e.pc; mret = e.ret;
        instruction = w; is_zero = z; run = 1'b1;
        got.cyc = 0; got.rw = 0; got.mw = 0; got.memc = 0; stl = 0;
        forever begin
            if (state == 3'd4) begin
                mem_ready = (stl >= stall);
                if (!mem_ready) stl++;
                got.memc++;
            end else begin
                mem_ready = 1'b0;
            end
            if (regwrite_en) got.rw++;
            if (memwrite_en) got.mw++;
            @(negedge clk);
            got.cyc++;
            if (state == 3'd1) break;
            if (got.cyc > 64) begin
                check_eq("fetch_timeout", 32'(got.cyc), 32'(e.cyc));
                break;
            end
        end
        if (sb.size() == 0) begin
            check_eq("sb_empty", 32'(0), 32'(1));
        end else begin
            e = sb.pop_front();
            check_eq($sformatf("pc_%h", w), 32'(pc), 32'(e.pc));
            check_eq($sformatf("cycles_%h", w), 32'(got.cyc), 32'(e.cyc));
            check_eq($sformatf("retired_%h", w), 32'(retired), 32'(e.ret));
            check_eq($sformatf("rw_pulses_%h", w), 32'(got.rw), 32'(e.rw));
            check_eq($sformatf("mw_cycles_%h", w), 32'(got.mw), 32'(e.mw));
            check_eq($sformatf("mem_cycles_%h", w), 32'(got.memc), 32'(e.memc));
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; run = 1'b0; instruction = 16'h0000; is_zero = 1'b0; mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        mpc = 16'h0000; mret = 16'h0000;
    endtask

    initial begin
        int hcnt;
        do_reset();
        check_eq("rst_state", 32'(state), 32'd0);
        check_eq("rst_pc", 32'(pc), 32'h0000);
        check_eq("rst_ir", 32'(ir), 32'h0000);
        check_eq("rst_retired", 32'(retired), 32'd0);
        check_eq("rst_rw_en", 32'(regwrite_en), 32'd0);
        check_eq("rst_mw_en", 32'(memwrite_en), 32'd0);
        check_eq("rst_halted", 32'(halted), 32'd0);

        // IDLE -> FETCH on run
        run = 1'b1;
        @(negedge clk);
        check_eq("idle_to_fetch", 32'(state), 32'd1);

        // ALU op at pc 0
        exec_instr(16'h0001, 1'b0, 0);
        check_eq("alu_pc_literal", 32'(pc), 32'h0001);

        // Pause in FETCH holds pc and ir
        run = 1'b0; instruction = 16'h1234;
        repeat (5) @(negedge clk);
        check_eq("pause_state", 32'(state), 32'd1);
        check_eq("pause_pc", 32'(pc), 32'h0001);
        check_eq("pause_ir", 32'(ir), 32'h0001);

        // Branches around pc 5
        exec_instr({3'b010, 13'd5}, 1'b0, 0);
        exec_instr({3'b001, 6'd0, 7'h7E}, 1'b1, 0);
        check_eq("br_taken_literal", 32'(pc), 32'h0004);
        exec_instr({3'b010, 13'd5}, 1'b0, 0);
        exec_instr({3'b001, 6'd0, 7'h7E}, 1'b0, 0);
        check_eq("br_not_taken_literal", 32'(pc), 32'h0006);

        // Store and load with a 3-cycle stall
        exec_instr({3'b100, 13'd0}, 1'b0, 3);
        exec_instr({3'b101, 13'd0}, 1'b0, 3);

        // Backward branch below zero, then jump and jump+branch in the E-page
        exec_instr({3'b001, 6'd0, 7'h40}, 1'b1, 0);
        exec_instr({3'b010, 13'h0004}, 1'b0, 0);
        check_eq("pc_e004", 32'(pc), 32'hE004);
        exec_instr({3'b011, 13'h0123}, 1'b1, 0);
        check_eq("jump_wins_literal", 32'(pc), 32'hE123);

        // Wrap at top of address space, then store+load
        exec_instr({3'b010, 13'h1FFF}, 1'b0, 0);
        exec_instr(16'h0002, 1'b0, 0);
        check_eq("wrap_literal", 32'(pc), 32'h0000);
        exec_instr({3'b110, 13'd0}, 1'b0, 0);

        // HALT at pc 2
        exec_instr({3'b010, 13'd2}, 1'b0, 0);
        instruction = 16'hFFFF;
        hcnt = 0;
        for (int i = 0; i < 22; i++) begin
            if (halted) hcnt++;
            @(negedge clk);
        end
        check_eq("halt_cycles", 32'(hcnt), 32'd20);
        check_eq("halt_state", 32'(state), 32'd6);
        check_eq("halt_flag", 32'(halted), 32'd1);
        check_eq("halt_pc", 32'(pc), 32'h0002);
        check_eq("halt_retired", 32'(retired), 32'(mret));

        // Async reset in the middle of a stalled store
        do_reset();
        run = 1'b1;
        @(negedge clk);
        instruction = {3'b100, 13'd0};
        mem_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("mid_mem_state", 32'(state), 32'd4);
        check_eq("mid_mem_mw_en", 32'(memwrite_en), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_rst_state", 32'(state), 32'd0);
        check_eq("async_rst_mw_en", 32'(memwrite_en), 32'd0);
        check_eq("async_rst_pc", 32'(pc), 32'h0000);
        check_eq("async_rst_retired", 32'(retired), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
